// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/single-step/BREAK sequencer driving the MIPS pipeline clock enable.
// Define CPU_RUN_CTRL_BRKPT_EN to add a PC breakpoint (brk_pc/brk_valid) to the stop condition.
module cpu_run_ctrl #(
  parameter int CLK_DIV = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic [31:0] ins_if,
  input  logic [31:0] pc_if,
`ifdef CPU_RUN_CTRL_BRKPT_EN
  input  logic [31:0] brk_pc,
  input  logic        brk_valid,
`endif
  output logic        cpu_en,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] cycle_cnt
);
  typedef enum logic [1:0] {HALT, RUN, STEP, STOP} state_t;
  state_t st;
  logic run_q, run_s, step_q, step_s, step_db_q;
  logic [15:0] div, db_cnt;
  logic step_db, step_req, div_end, brk;
  assign step_db = db_cnt == 16'(DEBOUNCE_CYCLES);
  assign step_req = step_db & ~step_db_q;
  assign div_end = div == 16'(CLK_DIV - 1);
  assign state = st;
`ifdef CPU_RUN_CTRL_BRKPT_EN
  assign brk = cpu_en & ((ins_if == 32'h0000000D) | (brk_valid & (pc_if == brk_pc)));
`else
  assign brk = cpu_en & (ins_if == 32'h0000000D);
  logic unused_pc;
  assign unused_pc = ^pc_if;
`endif
  // A pulse that retires a BREAK takes priority over everything, so it always lands in STOP
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {run_q, run_s, step_q, step_s, step_db_q} <= '0;
      db_cnt <= '0;
      div <= '0;
      st <= HALT;
      cpu_en <= 1'b0;
      halted <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      run_q <= run;
      run_s <= run_q;
      step_q <= step;
      step_s <= step_q;
      db_cnt <= !step_s ? '0 : step_db ? db_cnt : db_cnt + 16'd1;
      step_db_q <= step_db;
      cycle_cnt <= cycle_cnt + {31'd0, cpu_en};
      cpu_en <= 1'b0;
      div <= '0;
      case (st)
        HALT: st <= run_s ? RUN : step_req ? STEP : HALT;
        RUN:
          if (brk) begin
            st <= STOP;
            halted <= 1'b1;
          end else if (!run_s) st <= HALT;
          else begin
            cpu_en <= div_end;
            div <= div_end ? '0 : div + 16'd1;
          end
        STEP:
          if (brk) begin
            st <= STOP;
            halted <= 1'b1;
          end else if (cpu_en) st <= HALT;
          else cpu_en <= 1'b1;
        STOP:
          if (!run_s) begin
            st <= HALT;
            halted <= 1'b0;
          end
      endcase
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed checks of cpu_run_ctrl with CLK_DIV=1 (u1) and CLK_DIV=2 (u2).
module tb_cpu_run_ctrl;
  logic clk = 1'b0, reset = 1'b0, run = 1'b1, step = 1'b0;
  logic [31:0] ins_if = '0, pc_if = '0;
  logic en1, en2, h1, h2;
  logic [1:0] st1, st2;
  logic [31:0] cnt1, cnt2, c0;
`ifdef CPU_RUN_CTRL_BRKPT_EN
  logic [31:0] brk_pc = '0;
  logic brk_valid = 1'b0;
`endif
  int n_cmp = 0, n_bad = 0, e = 0, step_visits = 0, sv0;
  typedef struct {
    logic run, step;
    logic [31:0] ins;
    int clks;
    logic [1:0] st;
    logic hl;
    int dc;
  } vec_t;
  vec_t tv [17];
  always #5 clk = ~clk;
  always @(posedge clk) if (st1 == 2'd2) step_visits++;
  cpu_run_ctrl #(.CLK_DIV(1), .DEBOUNCE_CYCLES(4)) u1 (
    .clk(clk), .reset(reset), .run(run), .step(step), .ins_if(ins_if), .pc_if(pc_if),
`ifdef CPU_RUN_CTRL_BRKPT_EN
    .brk_pc(brk_pc), .brk_valid(brk_valid),
`endif
    .cpu_en(en1), .halted(h1), .state(st1), .cycle_cnt(cnt1));
  cpu_run_ctrl #(.CLK_DIV(2), .DEBOUNCE_CYCLES(4)) u2 (
    .clk(clk), .reset(reset), .run(run), .step(step), .ins_if(ins_if), .pc_if(pc_if),
`ifdef CPU_RUN_CTRL_BRKPT_EN
    .brk_pc(brk_pc), .brk_valid(brk_valid),
`endif
    .cpu_en(en2), .halted(h2), .state(st2), .cycle_cnt(cnt2));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask
  initial begin
    tv[0]  = '{1'b0, 1'b1, 32'h0, 3, 2'd0, 1'b0, 0};
    tv[1]  = '{1'b0, 1'b0, 32'h0, 8, 2'd0, 1'b0, 0};
    tv[2]  = '{1'b0, 1'b1, 32'h0, 6, 2'd0, 1'b0, 0};
    tv[3]  = '{1'b0, 1'b0, 32'h0, 1, 2'd2, 1'b0, 0};
    tv[4]  = '{1'b0, 1'b0, 32'h0, 1, 2'd2, 1'b0, 0};
    tv[5]  = '{1'b0, 1'b0, 32'h0, 1, 2'd0, 1'b0, 1};
    tv[6]  = '{1'b1, 1'b0, 32'hD, 3, 2'd1, 1'b0, 0};
    tv[7]  = '{1'b1, 1'b0, 32'hD, 1, 2'd1, 1'b0, 0};
    tv[8]  = '{1'b1, 1'b0, 32'hD, 1, 2'd3, 1'b1, 1};
    tv[9]  = '{1'b1, 1'b1, 32'hD, 8, 2'd3, 1'b1, 0};
    tv[10] = '{1'b0, 1'b0, 32'h0, 2, 2'd3, 1'b1, 0};
    tv[11] = '{1'b0, 1'b0, 32'h0, 1, 2'd0, 1'b0, 0};
    tv[12] = '{1'b1, 1'b0, 32'h0, 5, 2'd1, 1'b0, 1};
    tv[13] = '{1'b0, 1'b0, 32'h0, 3, 2'd0, 1'b0, 3};
    tv[14] = '{1'b1, 1'b1, 32'h0, 3, 2'd1, 1'b0, 0};
    tv[15] = '{1'b1, 1'b1, 32'h0, 5, 2'd1, 1'b0, 4};
    tv[16] = '{1'b0, 1'b0, 32'h0, 4, 2'd0, 1'b0, 3};
    tick(3);
    chk("rst_en", en2, 0);
    chk("rst_state", st2, 0);
    chk("rst_cnt", cnt2, 0);
    chk("rst_halted", h2, 0);
    reset = 1'b1;
    e = 0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      chk($sformatf("run_state2_e%0d", k), st2, k >= 3 ? 1 : 0);
      chk($sformatf("run_en2_e%0d", k), en2, (k >= 5 && k % 2 == 1) ? 1 : 0);
      chk($sformatf("run_en1_e%0d", k), en1, k >= 4 ? 1 : 0);
    end
    chk("cnt1_10", cnt1, 10);
    chk("cnt2_5", cnt2, 5);
    force u1.cycle_cnt = 32'hFFFFFFFF;
    #1 release u1.cycle_cnt;
    tick(1);
    chk("cnt_wrap", cnt1, 0);
    tick(1);
    chk("cnt_after_wrap", cnt1, 1);
    step = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k == 8) step = 1'b0;
      tick(1);
      chk("step_in_run_state", st2, 1);
      chk("step_in_run_en2", en2, e % 2 == 1 ? 1 : 0);
    end
    run = 1'b0;
    tick(4);
    chk("halt_state1", st1, 0);
    chk("halt_state2", st2, 0);
    chk("halt_en1", en1, 0);
    for (int i = 0; i < 17; i++) begin
      if (i == 14) sv0 = step_visits;
      run = tv[i].run;
      step = tv[i].step;
      ins_if = tv[i].ins;
      c0 = cnt1;
      tick(tv[i].clks);
      chk($sformatf("v%0d_state", i), st1, tv[i].st);
      chk($sformatf("v%0d_halted", i), h1, tv[i].hl);
      chk($sformatf("v%0d_dcnt", i), cnt1 - c0, tv[i].dc);
    end
    chk("no_step_on_run_and_step", step_visits - sv0, 0);
`ifdef CPU_RUN_CTRL_BRKPT_EN
    brk_pc = 32'h10;
    brk_valid = 1'b1;
    pc_if = 32'h10;
    run = 1'b1;
    c0 = cnt1;
    tick(5);
    chk("brkpt_state", st1, 3);
    chk("brkpt_dcnt", cnt1 - c0, 1);
    run = 1'b0;
    tick(4);
    brk_valid = 1'b0;
    run = 1'b1;
    tick(8);
    chk("brkpt_off_state", st1, 1);
    run = 1'b0;
    tick(4);
`endif
    run = 1'b1;
    tick(5);
    chk("pre_reset_en1", en1, 1);
    reset = 1'b0;
    #1;
    chk("async_reset_en1", en1, 0);
    chk("async_reset_state", st1, 0);
    chk("async_reset_cnt", cnt1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
